// File: rtl/uart_frame_unpacker_pkg.sv
// Shared definitions for the UART frame unpacker: field widths, the default
// header sync marker and the frame-assembly state encoding.
package uart_frame_unpacker_pkg;

    localparam int BYTE_W        = 8;
    localparam int CONTROL_W     = 6;
    localparam int FRAME_COUNT_W = 16;

    localparam logic [1:0] SYNC_DEFAULT = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/uart_frame_unpacker_if.sv
// Byte-stream input and assembled-word output bundle of the frame unpacker.
// The master side feeds received bytes and consumes results; the slave side
// is the unpacker itself.
interface uart_frame_unpacker_if #(
    parameter int WIDTH_DOUT = 128
);
    import uart_frame_unpacker_pkg::*;

    logic [BYTE_W-1:0]        rx_data;
    logic                     rx_valid;
    logic [WIDTH_DOUT-1:0]    dout;
    logic                     dout_valid;
    logic [CONTROL_W-1:0]     control;
    logic                     frame_err;
    logic [FRAME_COUNT_W-1:0] frame_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  dout,
        input  dout_valid,
        input  control,
        input  frame_err,
        input  frame_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output dout,
        output dout_valid,
        output control,
        output frame_err,
        output frame_count
    );

endinterface

// File: rtl/uart_frame_unpacker_byte_shift_assembler.sv
// Collects payload bytes MSB-first into a wide word. The output already
// includes a byte being shifted on the current edge, so the parent can
// capture the complete word on the same edge as the final byte.
module byte_shift_assembler
    import uart_frame_unpacker_pkg::*;
#(
    parameter int WIDTH_DOUT = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  clr,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic [WIDTH_DOUT-1:0] word
);

    logic [WIDTH_DOUT-1:0] word_q;
    logic [WIDTH_DOUT-1:0] word_d;

    // Clear wins over shift; a shift drops the oldest byte off the top.
    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (shift_en) begin
            word_d = WIDTH_DOUT'({word_q, byte_in});
        end
    end

    assign word = word_d;

    // Assembly register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/uart_frame_unpacker.sv
// Turns a UART byte stream into framed wide words: a header byte carrying a
// sync marker and control field, followed by WIDTH_DOUT/8 payload bytes.
// Bad headers and stalled frames are dropped and reported on frame_err.
module uart_frame_unpacker
    import uart_frame_unpacker_pkg::*;
#(
    parameter int         WIDTH_DOUT     = 128,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [1:0] SYNC           = SYNC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_unpacker_if.slave   bus
);

    localparam int NBYTES  = WIDTH_DOUT / BYTE_W;
    localparam int IDX_W   = $clog2(NBYTES + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NBYTES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_q,       state_d;
    logic [IDX_W-1:0]         idx_q,         idx_d;
    logic [TIMER_W-1:0]       timer_q,       timer_d;
    logic [CONTROL_W-1:0]     pend_ctrl_q,   pend_ctrl_d;
    logic [WIDTH_DOUT-1:0]    dout_q,        dout_d;
    logic [CONTROL_W-1:0]     control_q,     control_d;
    logic                     dout_valid_q,  dout_valid_d;
    logic                     frame_err_q,   frame_err_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    logic                     shift_en;
    logic                     clr;
    logic [WIDTH_DOUT-1:0]    asm_word;
    logic [TIMER_W-1:0]       timer_inc;

    byte_shift_assembler #(
        .WIDTH_DOUT (WIDTH_DOUT)
    ) u_assembler (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (clr),
        .byte_in  (bus.rx_data),
        .word     (asm_word)
    );

    assign timer_inc = timer_q + TIMER_W'(1);

    // Frame state machine: header check, payload counting, idle timeout and
    // the next values of every registered output.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        pend_ctrl_d   = pend_ctrl_q;
        dout_d        = dout_q;
        control_d     = control_q;
        dout_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        shift_en      = 1'b0;
        clr           = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[7:6] == SYNC) begin
                        pend_ctrl_d = bus.rx_data[CONTROL_W-1:0];
                        clr         = 1'b1;
                        idx_d       = '0;
                        timer_d     = '0;
                        state_d     = PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            PAYLOAD: begin
                if (bus.rx_valid) begin
                    shift_en = 1'b1;
                    timer_d  = '0;
                    if (idx_q == LAST_IDX) begin
                        dout_d        = asm_word;
                        control_d     = pend_ctrl_q;
                        dout_valid_d  = 1'b1;
                        frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
                        idx_d         = '0;
                        state_d       = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timer_inc >= TIMER_LIMIT) begin
                    frame_err_d = 1'b1;
                    timer_d     = '0;
                    idx_d       = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered; active-low asynchronous reset
    // discards any partial frame without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            pend_ctrl_q   <= '0;
            dout_q        <= '0;
            control_q     <= '0;
            dout_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            pend_ctrl_q   <= pend_ctrl_d;
            dout_q        <= dout_d;
            control_q     <= control_d;
            dout_valid_q  <= dout_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.control     = control_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_frame_unpacker.sv
// Self-checking bench for uart_frame_unpacker at a 32-bit payload and a
// 20-cycle idle timeout. A queue-based frame model predicts every output
// after each clock; directed steps also pin the headline values.
module tb_uart_frame_unpacker;

    localparam int W  = 32;
    localparam int NB = W / 8;
    localparam int TO = 20;

    logic clk;
    logic rst;

    uart_frame_unpacker_if #(.WIDTH_DOUT(W)) bus ();

    uart_frame_unpacker #(
        .WIDTH_DOUT     (W),
        .TIMEOUT_CYCLES (TO),
        .SYNC           (2'b10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the frame protocol
    bit          m_in_frame;
    logic [7:0]  m_bytes[$];
    logic [5:0]  m_pend;
    int          m_idle;
    logic [W-1:0] m_dout;
    logic [5:0]  m_ctrl;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_count;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_bytes.delete();
        m_pend  = '0;
        m_idle  = 0;
        m_dout  = '0;
        m_ctrl  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_count = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic [W-1:0] w;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_in_frame) begin
            if (v) begin
                if (d[7:6] == 2'b10) begin
                    m_in_frame = 1;
                    m_pend     = d[5:0];
                    m_bytes.delete();
                    m_idle     = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (v) begin
            m_bytes.push_back(d);
            m_idle = 0;
            if (m_bytes.size() == NB) begin
                w = '0;
                foreach (m_bytes[i]) w = (w << 8) | W'(m_bytes[i]);
                m_dout     = w;
                m_ctrl     = m_pend;
                m_valid    = 1'b1;
                m_count    = m_count + 16'd1;
                m_in_frame = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO - 1) begin
                m_err      = 1'b1;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic check_output();
        check("dout",        bus.dout,               m_dout);
        check("control",     32'(bus.control),       32'(m_ctrl));
        check("dout_valid",  32'(bus.dout_valid),    32'(m_valid));
        check("frame_err",   32'(bus.frame_err),     32'(m_err));
        check("frame_count", 32'(bus.frame_count),   32'(m_count));
    endtask

    // One clock: drive a byte (or idle), advance the model, compare
    task automatic apply_stimulus(input logic v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = v ? d : 8'($urandom);
        @(posedge clk);
        #1;
        model_step(v, d);
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00);
    endtask

    // Header plus payload with a fixed gap between bytes, no trailing gap
    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] payload, input int gap);
        apply_stimulus(1'b1, hdr);
        for (int i = 0; i < NB; i++) begin
            idle(gap);
            apply_stimulus(1'b1, payload[31 - 8*i -: 8]);
        end
    endtask

    initial begin
        int err_at;
        int kind;
        int gap;
        logic [7:0] hdr;

        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_output();
        rst = 1'b1;

        $display("[TB] basic frame with 3-clock spacing");
        send_frame(8'h81, 32'h12345678, 3);
        check("t1_dout",    bus.dout,                32'h12345678);
        check("t1_control", 32'(bus.control),        32'h01);
        check("t1_valid",   32'(bus.dout_valid),     32'h1);
        check("t1_count",   32'(bus.frame_count),    32'h1);
        idle(1);
        check("t1_valid_one_cycle", 32'(bus.dout_valid), 32'h0);
        idle(2);

        $display("[TB] bad header then good frame");
        apply_stimulus(1'b1, 8'h45);
        check("t2_err",      32'(bus.frame_err),  32'h1);
        check("t2_no_valid", 32'(bus.dout_valid), 32'h0);
        send_frame(8'hBF, 32'hAABBCCDD, 0);
        check("t2_dout",    bus.dout,         32'hAABBCCDD);
        check("t2_control", 32'(bus.control), 32'h3F);
        idle(2);

        $display("[TB] stalled frame times out");
        apply_stimulus(1'b1, 8'h80);
        apply_stimulus(1'b1, 8'h11);
        apply_stimulus(1'b1, 8'h22);
        err_at = -1;
        for (int k = 1; k <= 25; k++) begin
            apply_stimulus(1'b0, 8'h00);
            if (bus.frame_err === 1'b1 && err_at < 0) err_at = k;
        end
        check("t3_timeout_at", 32'(err_at),       32'd19);
        check("t3_dout_kept",  bus.dout,          32'hAABBCCDD);
        check("t3_ctrl_kept",  32'(bus.control),  32'h3F);
        send_frame(8'h8A, 32'hCAFEF00D, 1);
        check("t3_recover", bus.dout, 32'hCAFEF00D);
        idle(1);

        $display("[TB] byte on the expiring cycle is accepted");
        apply_stimulus(1'b1, 8'h82);
        apply_stimulus(1'b1, 8'h01);
        idle(TO - 2);
        apply_stimulus(1'b1, 8'h02);
        check("t3b_no_err", 32'(bus.frame_err), 32'h0);
        apply_stimulus(1'b1, 8'h03);
        apply_stimulus(1'b1, 8'h04);
        check("t3b_dout", bus.dout, 32'h01020304);
        idle(1);

        $display("[TB] back-to-back frames");
        send_frame(8'h90, 32'($urandom), 0);
        send_frame(8'hA5, 32'($urandom), 0);
        check("t4_count", 32'(bus.frame_count), 32'd6);
        idle(2);

        $display("[TB] reset in the middle of a frame");
        apply_stimulus(1'b1, 8'h83);
        apply_stimulus(1'b1, 8'h5A);
        apply_stimulus(1'b1, 8'hA5);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_output();
        repeat (2) @(posedge clk);
        #1;
        check_output();
        rst = 1'b1;
        idle(3);
        send_frame(8'h84, 32'h0BADBEEF, 0);
        check("t5_dout",  bus.dout,              32'h0BADBEEF);
        check("t5_count", 32'(bus.frame_count),  32'd1);
        idle(1);

        $display("[TB] randomized traffic");
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                hdr = 8'($urandom);
                if (hdr[7:6] == 2'b10) hdr[7:6] = 2'b11;
            end else begin
                hdr = {2'b10, 6'($urandom)};
            end
            apply_stimulus(1'b1, hdr);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(TO - 2, TO + 2));
                else gap = int'($urandom_range(0, 2));
                idle(gap);
                apply_stimulus(1'b1, 8'($urandom));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(TO);

        $display("[TB] frame counter wrap");
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        m_count = 16'hFFFF;
        idle(1);
        send_frame(8'hBC, 32'h55AA55AA, 0);
        check("t6_wrap",       32'(bus.frame_count), 32'h0);
        check("t6_wrap_valid", 32'(bus.dout_valid),  32'h1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_unpacker.md
Name: uart_frame_unpacker

Overview:
- Upstream stage of the coprocessor. Consumes the byte stream from the UART receiver and assembles framed packets into one wide word.
- Each frame is a header byte followed by WIDTH_DOUT/8 payload bytes. The header carries a sync marker and the 6-bit control field.
- The block presents dout/dout_valid/control ready to wire directly to the coprocessor's din/din_valid/control.
- Also rejects malformed or stalled frames and flags them.

Parameters:
- WIDTH_DOUT, 128, payload word width in bits; must be a multiple of 8 and at least 8; NBYTES = WIDTH_DOUT/8.
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between consecutive bytes inside one frame.
- SYNC, 2'b10, required value of header bits [7:6].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- dout  out  WIDTH_DOUT  assembled payload; first received byte lands in dout[WIDTH_DOUT-1 -: 8].
- dout_valid  out  1  one-cycle pulse; dout is valid in that cycle and holds until the next frame completes.
- control  out  6  header bits [5:0] of the last completed frame; updates in the same cycle as dout_valid.
- frame_err  out  1  one-cycle pulse on bad header or timeout.
- frame_count  out  16  count of completed good frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=0, async): state=IDLE; dout=0, dout_valid=0, control=0, frame_err=0, frame_count=0; byte index and timeout counter cleared.
- Reset mid-frame: the partial frame is discarded. No dout_valid or frame_err is produced for it.
- IDLE, rx_valid with rx_data[7:6]==SYNC:
  - Latch rx_data[5:0] into a pending-control register (not the output).
  - Clear the shift register, idx=0, timer=0; go to PAYLOAD.
- IDLE, rx_valid with a bad header: pulse frame_err next cycle; stay IDLE; byte dropped.
- IDLE, no rx_valid: hold.
- PAYLOAD, rx_valid:
  - Shift the byte into the assembly register MSB-first; timer=0; idx++.
  - If this was byte NBYTES-1, the next edge (latency 1 clock after the last byte's strobe):
    - dout <= assembled word, control <= pending control, dout_valid=1, frame_count++;
    - state -> IDLE.
- PAYLOAD, no rx_valid: timer++.
  - When timer reaches TIMEOUT_CYCLES-1 without a byte: frame_err pulse, state -> IDLE.
  - dout, control and frame_count are unchanged.
- A byte arriving on the same edge the timer expires is accepted, i.e. rx_valid takes priority over timeout.
- A header byte may arrive in the cycle immediately after dout_valid. IDLE is entered on the completion edge, so back-to-back frames with zero gap are supported.
- Payload bytes are never checked for sync; any value is data.
- dout_valid and frame_err are never high in the same cycle.
- No backpressure: the downstream stage must accept every dout_valid pulse.
- Counter widths: idx is $clog2(NBYTES+1) bits; timer is $clog2(TIMEOUT_CYCLES+1) bits; all counters are unsigned.

Decomposition:
- Shared package (uart_pkg): SYNC default, the state enum {IDLE, PAYLOAD}, CONTROL_W=6, BYTE_W=8.
- One natural sub-module, byte_shift_assembler:
  - parameterized by WIDTH_DOUT;
  - inputs shift_en, clr and byte;
  - output the assembled word.
- The FSM, timer and output registers stay in the top module.

Test Plan (bench at WIDTH_DOUT=32, TIMEOUT_CYCLES=20):
- Header 0x81, then bytes 0x12,0x34,0x56,0x78 spaced 3 clocks -> one cycle after the last strobe: dout=0x12345678, control=6'h01, dout_valid=1 for exactly 1 clock, frame_count=1.
- Header 0x45 (bad sync) -> frame_err pulse 1 clock later, no dout_valid; then a good frame 0xBF,AA,BB,CC,DD -> dout=0xAABBCCDD, control=6'h3F.
- Header 0x80, two payload bytes, then 25 idle clocks -> frame_err pulse at idle clock 19, dout/control unchanged from the prior frame; a following good frame decodes correctly.
- Two frames back-to-back, header of frame 2 one cycle after dout_valid of frame 1 -> two dout_valid pulses with correct words; frame_count advances by 2.
- rst driven low after 2 payload bytes, then released and a full frame sent -> outputs 0 during reset, no pulse from the aborted frame, new frame decodes and frame_count=1.
- Preload frame_count to 0xFFFF via 65535 frames (or a forced value), then one more frame -> frame_count=0x0000.
